// File: rtl/divider_sequencer.sv
// Sequential restoring divider, signed/unsigned, one quotient bit per cycle; done after DATA_WIDTH+1 edges.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase (done one edge after start).
module divider_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_in,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    prem;
  logic [W-1:0]    qsh;
  logic [W-1:0]    dvs;
  logic [W-1:0]    orig_dvd;
  logic            neg_q, neg_r, dz;

  logic            sign_a, sign_b;
  logic [W-1:0]    dvd_abs, dvs_abs;
  logic [W:0]      shifted, trial;
  logic            start;

  // Magnitudes by xor with the sign mask then subtracting it; the most negative value maps to 2^(W-1).
  assign sign_a  = is_signed & dividend[W-1];
  assign sign_b  = is_signed & divisor[W-1];
  assign dvd_abs = (dividend ^ {W{sign_a}}) - {W{sign_a}};
  assign dvs_abs = (divisor  ^ {W{sign_b}}) - {W{sign_b}};
  assign start   = (state == IDLE) && enable_in;

  assign shifted = {prem, qsh[W-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable_in) begin
`ifdef DIV_ZERO_FAST_EN
        state_nxt = (divisor == '0) ? FIX : ITER;
`else
        state_nxt = ITER;
`endif
      end
      ITER: if (cnt == CW'(W - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      prem     <= '0;
      qsh      <= '0;
      dvs      <= '0;
      orig_dvd <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
    end else if (start) begin
      cnt      <= '0;
      prem     <= '0;
      qsh      <= dvd_abs;
      dvs      <= dvs_abs;
      orig_dvd <= dividend;
      neg_q    <= sign_a ^ sign_b;
      neg_r    <= sign_a;
      dz       <= (divisor == '0);
    end else if (state == ITER) begin
      // Restore on a negative trial (borrow into bit W), otherwise keep the difference.
      cnt  <= cnt + 1'b1;
      prem <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
      qsh  <= {qsh[W-2:0], ~trial[W]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        quotient    <= dz ? '1       : (neg_q ? -qsh  : qsh);
        remainder   <= dz ? orig_dvd : (neg_r ? -prem : prem);
        div_by_zero <= dz;
      end
    end
  end

endmodule

// File: doc/divider_sequencer.md
DIVIDER_SEQUENCER -- requirements
Module: divider_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits (>= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable_in  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with enable_in.
REQ-006 SHALL have port dividend  input  DATA_WIDTH  numerator, sampled with enable_in.
REQ-007 SHALL have port divisor  input  DATA_WIDTH  denominator, sampled with enable_in.
REQ-008 SHALL have port quotient  output  DATA_WIDTH  registered quotient.
REQ-009 SHALL have port remainder  output  DATA_WIDTH  registered remainder.
REQ-010 SHALL have port div_by_zero  output  1  registered; set with done when divisor was zero.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when quotient/remainder are valid.

Function
REQ-013 SHALL implement states IDLE, ITER, FIX; IDLE->ITER on sampled enable_in, ITER->FIX after DATA_WIDTH iteration edges, FIX->IDLE unconditionally.
REQ-014 On start, in signed mode, SHALL load magnitudes abs(dividend), abs(divisor) via sign-xor-then-subtract; in unsigned mode SHALL load raw operands; SHALL latch operand signs.
REQ-015 abs of the most negative value SHALL be treated as unsigned 2^(DATA_WIDTH-1) (no saturation).
REQ-016 ITER SHALL perform one restoring shift-subtract step per cycle on a DATA_WIDTH+1-bit partial remainder, producing one quotient bit per cycle, MSB first; a cycle counter SHALL count 0..DATA_WIDTH-1.
REQ-017 FIX SHALL register results: quotient negated when signed and operand signs differ; remainder negated when signed and dividend negative; done=1 for exactly this edge's following cycle.
REQ-018 Latency: sampling edge E0; done high after edge E0+DATA_WIDTH+1, low after E0+DATA_WIDTH+2.
REQ-019 Divisor zero SHALL yield quotient all ones, remainder = original dividend, div_by_zero=1, regardless of is_signed.
REQ-020 Signed overflow (most negative / -1) SHALL yield quotient = most negative, remainder 0, div_by_zero=0.
REQ-021 enable_in while busy SHALL be ignored; no queueing.
REQ-022 quotient, remainder, div_by_zero SHALL hold their values until the next FIX; enable_in in the same cycle as done is accepted only once state is IDLE (cycle after FIX).
REQ-023 Operand inputs SHALL not need to remain stable after the sampling edge.

Reset
REQ-024 reset_n low SHALL asynchronously force state IDLE, counter 0, quotient 0, remainder 0, div_by_zero 0, busy 0, done 0.
REQ-025 Reset during ITER or FIX SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro DIV_ZERO_FAST_EN defined: divisor zero at start SHALL go IDLE->FIX directly, done after edge E0+1, same results as REQ-019.
REQ-027 Macro DIV_ZERO_FAST_EN undefined: divisor zero SHALL run the full ITER sequence with latency per REQ-018 and results per REQ-019.

Verification
REQ-028 Signed 100 / 7 -> quotient 14, remainder 2, done exactly after edge E0+33 (DATA_WIDTH=32), busy high E0+1..E0+33.
REQ-029 Signed -100 / 7 -> quotient -14 (0xFFFFFFF2), remainder -2 (0xFFFFFFFE); signed 100 / -7 -> quotient -14, remainder 2.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF / 2 -> quotient 0x7FFFFFFF, remainder 1.
REQ-031 Dividend 0x12345678 / 0, both modes -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1; done after E0+1 with DIV_ZERO_FAST_EN, after E0+33 without.
REQ-032 Start 100/7, pulse enable_in with 50/5 at iteration 10, assert reset_n low at iteration 20 -> second start ignored, no done, all outputs 0; restart 50/5 -> quotient 10, remainder 0.
